// File: rtl/fa_pkg.sv
// Shared constants for the full-adder statistics slice: counter width default
// and the counter overflow mode encoding.
package fa_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum bit {
        SAT_WRAP = 1'b0,
        SAT_HOLD = 1'b1
    } sat_mode_e;

endpackage

// File: rtl/fa_half_adder.sv
// Single-bit half adder; two of these plus an OR make the full-adder core.
module half_adder
    import fa_pkg::*;
(
    input  logic x,
    input  logic y,
    output logic sum,
    output logic carry
);

    assign sum   = x ^ y;
    assign carry = x & y;

endmodule

// File: rtl/fa.sv
// Gate-form full adder with registered outputs, operation/carry statistics
// counters and a sticky arithmetic self-check against a+b+c.
module fa
    import fa_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             cnt_clr,
    output logic             s,
    output logic             cout,
    output logic             s_q,
    output logic             cout_q,
    output logic [CNT_W-1:0] op_cnt,
    output logic [CNT_W-1:0] carry_cnt,
    output logic             chk_err
);

    logic       ha0_sum;
    logic       ha0_carry;
    logic       ha1_carry;
    logic       gate_cout;
    logic [1:0] ref_sum;
    logic       mismatch;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        if ((v == {CNT_W{1'b1}}) && (SAT_EN == bit'(SAT_HOLD)))
            return v;
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    half_adder u_ha0 (.x(a),       .y(b), .sum(ha0_sum), .carry(ha0_carry));
    half_adder u_ha1 (.x(ha0_sum), .y(c), .sum(s),       .carry(ha1_carry));

    assign gate_cout = ha0_carry | ha1_carry;
    assign cout      = gate_cout;

    // Independent arithmetic reference; any disagreement with the gate form latches chk_err.
    assign ref_sum  = {1'b0, a} + {1'b0, b} + {1'b0, c};
    assign mismatch = (ref_sum != {gate_cout, s});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= 1'b0;
            cout_q    <= 1'b0;
            op_cnt    <= '0;
            carry_cnt <= '0;
            chk_err   <= 1'b0;
        end else begin
            s_q     <= s;
            cout_q  <= gate_cout;
            chk_err <= chk_err | mismatch;
            if (cnt_clr) begin
                op_cnt    <= '0;
                carry_cnt <= '0;
            end else begin
                op_cnt <= cnt_inc(op_cnt);
                if (gate_cout)
                    carry_cnt <= cnt_inc(carry_cnt);
            end
        end
    end

endmodule

// File: tb/tb_fa.sv
// Randomized and directed bench for fa: three instances (16-bit saturating,
// 4-bit saturating, 4-bit wrapping) checked against an arithmetic model.
module tb_fa;

    logic clk;
    logic clk_en;
    logic rst_n;
    logic a, b, c, cnt_clr;

    logic        s0, cout0, sq0, cq0, err0;
    logic [15:0] op0, cy0;
    logic        s1, cout1, sq1, cq1, err1;
    logic [3:0]  op1, cy1;
    logic        s2, cout2, sq2, cq2, err2;
    logic [3:0]  op2, cy2;

    int checks;
    int failures;

    int exp_op [3];
    int exp_cy [3];
    int exp_sq [3];
    int exp_cq [3];
    int exp_chk[3];
    int cw     [3];
    bit csat   [3];
    int tbl    [8];

    fa #(.CNT_W(16), .SAT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .cnt_clr(cnt_clr),
        .s(s0), .cout(cout0), .s_q(sq0), .cout_q(cq0),
        .op_cnt(op0), .carry_cnt(cy0), .chk_err(err0));

    fa #(.CNT_W(4), .SAT_EN(1'b1)) dut_sat4 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .cnt_clr(cnt_clr),
        .s(s1), .cout(cout1), .s_q(sq1), .cout_q(cq1),
        .op_cnt(op1), .carry_cnt(cy1), .chk_err(err1));

    fa #(.CNT_W(4), .SAT_EN(1'b0)) dut_wrap4 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .cnt_clr(cnt_clr),
        .s(s2), .cout(cout2), .s_q(sq2), .cout_q(cq2),
        .op_cnt(op2), .carry_cnt(cy2), .chk_err(err2));

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int inc(input int v, input int w, input bit sat);
        int lim;
        lim = (1 << w);
        if (sat) return (v + 1 < lim) ? v + 1 : lim - 1;
        return (v + 1) % lim;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            exp_op[i] = 0; exp_cy[i] = 0; exp_sq[i] = 0; exp_cq[i] = 0; exp_chk[i] = 0;
        end
    endtask

    task automatic check_comb(input string tag);
        int sum;
        sum = int'(a) + int'(b) + int'(c);
        chk({tag, ".s0"},    int'(s0),    sum % 2);
        chk({tag, ".cout0"}, int'(cout0), sum / 2);
        chk({tag, ".s2"},    int'(s2),    sum % 2);
        chk({tag, ".cout2"}, int'(cout2), sum / 2);
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".sq0"},  int'(sq0),  exp_sq[0]);
        chk({tag, ".cq0"},  int'(cq0),  exp_cq[0]);
        chk({tag, ".op0"},  int'(op0),  exp_op[0]);
        chk({tag, ".cy0"},  int'(cy0),  exp_cy[0]);
        chk({tag, ".err0"}, int'(err0), exp_chk[0]);
        chk({tag, ".sq1"},  int'(sq1),  exp_sq[1]);
        chk({tag, ".cq1"},  int'(cq1),  exp_cq[1]);
        chk({tag, ".op1"},  int'(op1),  exp_op[1]);
        chk({tag, ".cy1"},  int'(cy1),  exp_cy[1]);
        chk({tag, ".err1"}, int'(err1), exp_chk[1]);
        chk({tag, ".op2"},  int'(op2),  exp_op[2]);
        chk({tag, ".cy2"},  int'(cy2),  exp_cy[2]);
        chk({tag, ".err2"}, int'(err2), exp_chk[2]);
    endtask

    // Apply one operation at a low clock phase, advance one edge, update the model, check.
    task automatic step(input string tag, input logic ia, input logic ib, input logic ic,
                        input logic iclr, input bit force_carry);
        int sum;
        int carry_seen;
        a = ia; b = ib; c = ic; cnt_clr = iclr;
        if (force_carry) force dut.gate_cout = 1'b1;
        @(posedge clk);
        sum = int'(ia) + int'(ib) + int'(ic);
        for (int i = 0; i < 3; i++) begin
            carry_seen = (force_carry && i == 0) ? 1 : sum / 2;
            exp_sq[i] = sum % 2;
            exp_cq[i] = carry_seen;
            if (force_carry && i == 0 && carry_seen != sum / 2) exp_chk[i] = 1;
            if (iclr) begin
                exp_op[i] = 0;
                exp_cy[i] = 0;
            end else begin
                exp_op[i] = inc(exp_op[i], cw[i], csat[i]);
                if (carry_seen == 1) exp_cy[i] = inc(exp_cy[i], cw[i], csat[i]);
            end
        end
        #1;
        if (force_carry) release dut.gate_cout;
        check_regs(tag);
        @(negedge clk);
    endtask

    initial begin
        int r;
        checks = 0; failures = 0;
        cw[0] = 16; cw[1] = 4; cw[2] = 4;
        csat[0] = 1'b1; csat[1] = 1'b1; csat[2] = 1'b0;
        tbl = '{0, 1, 1, 2, 1, 2, 2, 3};
        model_reset();
        clk_en = 1'b0;
        a = 1'b0; b = 1'b0; c = 1'b0; cnt_clr = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_regs("reset");

        // Combinational sweep with the clock idle and reset held.
        for (int v = 0; v < 8; v++) begin
            r = v;
            {a, b, c} = r[2:0];
            #10;
            chk($sformatf("sweep%0d", v), int'({cout0, s0}), tbl[v]);
            check_comb($sformatf("sweep%0d", v));
        end
        check_regs("idle");

        rst_n = 1'b1;
        #2 clk_en = 1'b1;

        // Clocked sweep from reset.
        for (int v = 0; v < 8; v++) begin
            r = v;
            step($sformatf("csweep%0d", v), r[2], r[1], r[0], 1'b0, 1'b0);
        end
        chk("csweep.op8", int'(op0), 8);
        chk("csweep.cy4", int'(cy0), 4);
        chk("csweep.err", int'(err0), 0);

        // Clear with a carry present wins over increment, then counting resumes.
        step("clr", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr.op", int'(op0), 0);
        chk("clr.cy", int'(cy0), 0);
        step("resume", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("resume.cy", int'(cy0), 1);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom);
            check_comb("rnd_comb");
            step("rnd", r[0], r[1], r[2], (r[5:3] == 3'd0), 1'b0);
        end

        // 20 carrying cycles: 4-bit counters saturate at 15 or wrap to 4.
        step("satclr", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step("sat", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("sat.op1", int'(op1), 15);
        chk("sat.cy1", int'(cy1), 15);
        chk("wrap.op2", int'(op2), 4);
        chk("wrap.cy2", int'(cy2), 4);

        // Corrupt the gate-form carry for one cycle; the flag must survive clears.
        step("force", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("force.err", int'(err0), 1);
        step("force_clr", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step("force_hold", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("force.sticky", int'(err0), 1);

        // Five counted cycles, then an asynchronous reset between edges.
        step("pre_rst_clr", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            r = int'($urandom);
            step("pre_rst", r[0], r[1], r[2], 1'b0, 1'b0);
        end
        chk("pre_rst.op", int'(op0), 5);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_regs("async_rst");
        chk("async_rst.err", int'(err0), 0);
        a = 1'b1; b = 1'b1; c = 1'b0;
        #1 check_comb("rst_comb110");
        a = 1'b0; b = 1'b0; c = 1'b1;
        #1 check_comb("rst_comb001");
        @(posedge clk);
        #1 check_regs("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_rst.op", int'(op0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
